conv2d_output_sequencer: RTL and testbench

CONV2D_OUTPUT_SEQUENCER -- requirements
Module: conv2d_output_sequencer

---
 rtl/conv2d_pkg.sv | 15 +
 rtl/conv2d_params.svh | 6 +
 rtl/conv2d_vec_fifo.sv | 53 +++++
 rtl/conv2d_output_sequencer.sv | 170 +++++++++++++++++
 tb/tb_conv2d_output_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_pkg.sv
// Shared types for the conv2d output path: sequencer FSM state plus accumulator and INT8 pixel vectors.
package conv2d_pkg;
`include "conv2d_params.svh"

   localparam int PIX_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_state_e;

   typedef logic signed [NUM_OUT_CHANNELS-1:0][ACC_WIDTH-1:0] acc_vec_t;
   typedef logic        [NUM_OUT_CHANNELS-1:0][PIX_WIDTH-1:0] pix_vec_t;
endpackage

// File: rtl/conv2d_params.svh
// Array-wide conv2d dimensions shared by every block built on conv2d_pkg.
`ifndef CONV2D_PARAMS_SVH
`define CONV2D_PARAMS_SVH
localparam int NUM_OUT_CHANNELS = 4;
localparam int ACC_WIDTH        = 24;
`endif

// File: rtl/conv2d_vec_fifo.sv
// Synchronous vector FIFO with a show-ahead head and occupancy count; DEPTH must be a power of two.
module conv2d_vec_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // A push into a full FIFO is dropped here; the producer's credit logic must prevent it.
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
endmodule

// File: rtl/conv2d_output_sequencer.sv
// Frame sequencer between the MAC array, the external activation stage and the output pixel stream.
// Optional stall counters are built when CONV2D_SEQ_PERF_EN is defined.
module conv2d_output_sequencer
   import conv2d_pkg::*;
#(
   parameter int OUT_FIFO_DEPTH = 4,
   parameter int DIM_WIDTH      = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  cfg_out_w,
   input  logic [DIM_WIDTH-1:0]  cfg_out_h,
   output logic                  busy,
   output logic                  done,
   input  acc_vec_t              acc_vec,
   input  logic                  acc_valid,
   output logic                  acc_ready,
   output acc_vec_t              act_in_vec,
   output logic                  act_in_valid,
   input  pix_vec_t              act_out_vec,
   input  logic                  act_out_valid,
   output pix_vec_t              m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last_col,
   output logic                  m_last_frame,
   output seq_state_e            o_dbg_state
`ifdef CONV2D_SEQ_PERF_EN
   ,
   output logic [31:0]           perf_stall_in,
   output logic [31:0]           perf_stall_out
`endif
);
   localparam int CW = $clog2(OUT_FIFO_DEPTH) + 1;
   localparam int TW = 2 * DIM_WIDTH;

   // Both streams use valid/ready: a transfer happens on a rising edge where valid && ready.
   seq_state_e           r_state;
   seq_state_e           w_next_state;
   logic [DIM_WIDTH-1:0] r_w;
   logic [DIM_WIDTH-1:0] r_h;
   logic [DIM_WIDTH-1:0] r_out_col;
   logic [DIM_WIDTH-1:0] r_out_row;
   logic [TW-1:0]        r_total;
   logic [TW-1:0]        r_issued;
   logic                 r_inflight;
   logic                 r_done;
   logic [CW-1:0]        w_fifo_count;
   logic [CW:0]          w_occupancy;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic                 w_pop;
   logic                 w_dims_ok;
   logic                 w_start_ok;
   logic                 w_start_zero;
   logic                 w_last_issue;
   logic                 w_frame_end;

   assign w_dims_ok    = (cfg_out_w != '0) && (cfg_out_h != '0);
   assign w_start_ok   = (r_state == IDLE) && start && w_dims_ok;
   assign w_start_zero = (r_state == IDLE) && start && !w_dims_ok;

   // A vector in the activation stage already owns a FIFO slot, so it counts against the credit.
   assign w_occupancy  = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight};
   assign acc_ready    = (r_state == RUN) && (w_occupancy < (CW+1)'(OUT_FIFO_DEPTH));
   assign act_in_vec   = acc_vec;
   assign act_in_valid = acc_valid && acc_ready;
   assign w_last_issue = act_in_valid && ((r_issued + TW'(1)) == r_total);

   assign m_valid      = !w_fifo_empty;
   assign w_pop        = m_valid && m_ready;
   assign m_last_col   = (r_out_col == r_w - DIM_WIDTH'(1));
   assign m_last_frame = m_last_col && (r_out_row == r_h - DIM_WIDTH'(1));
   assign w_frame_end  = (r_state == DRAIN) && w_pop && m_last_frame;

   assign busy         = (r_state != IDLE);
   assign done         = r_done;
   assign o_dbg_state  = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_start_ok)   w_next_state = RUN;
         RUN:     if (w_last_issue) w_next_state = DRAIN;
         DRAIN:   if (w_frame_end)  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w        <= '0;
         r_h        <= '0;
         r_total    <= '0;
         r_issued   <= '0;
         r_out_col  <= '0;
         r_out_row  <= '0;
         r_inflight <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_inflight <= act_in_valid;
         r_done     <= w_start_zero || w_frame_end;
         if (w_start_ok) begin
            r_w       <= cfg_out_w;
            r_h       <= cfg_out_h;
            r_total   <= TW'(cfg_out_w) * TW'(cfg_out_h);
            r_issued  <= '0;
            r_out_col <= '0;
            r_out_row <= '0;
         end else begin
            if (act_in_valid) r_issued <= r_issued + TW'(1);
            if (w_pop) begin
               if (m_last_col) begin
                  r_out_col <= '0;
                  r_out_row <= r_out_row + DIM_WIDTH'(1);
               end else begin
                  r_out_col <= r_out_col + DIM_WIDTH'(1);
               end
            end
         end
      end
   end

   conv2d_vec_fifo #(
      .DEPTH (OUT_FIFO_DEPTH),
      .WIDTH ($bits(pix_vec_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (act_out_valid),
      .i_wdata (act_out_vec),
      .i_pop   (w_pop),
      .o_rdata (m_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(act_out_valid && w_fifo_full));

`ifdef CONV2D_SEQ_PERF_EN
   logic [31:0] r_perf_in;
   logic [31:0] r_perf_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_in  <= '0;
         r_perf_out <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_perf_in  <= '0;
         r_perf_out <= '0;
      end else begin
         if ((r_state == RUN) && acc_valid && !acc_ready && (r_perf_in != '1))
            r_perf_in <= r_perf_in + 32'd1;
         if (m_valid && !m_ready && (r_perf_out != '1))
            r_perf_out <= r_perf_out + 32'd1;
      end
   end

   assign perf_stall_in  = r_perf_in;
   assign perf_stall_out = r_perf_out;
`endif
endmodule

// File: tb/tb_conv2d_output_sequencer.sv
// Directed bench for conv2d_output_sequencer with a 1-cycle ReLU/saturate activation model in the loop.
module tb_conv2d_output_sequencer;
   import conv2d_pkg::*;

   localparam int DEPTH = 4;
   localparam int DW    = 10;
   localparam int PW    = NUM_OUT_CHANNELS * 8;
   localparam int MAXV  = 64;

   typedef struct {
      int acc [NUM_OUT_CHANNELS];
      int pix [NUM_OUT_CHANNELS];
   } vec_rec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] cfg_out_w;
   logic [DW-1:0] cfg_out_h;
   logic          busy;
   logic          done;
   acc_vec_t      acc_vec;
   logic          acc_valid;
   logic          acc_ready;
   acc_vec_t      act_in_vec;
   logic          act_in_valid;
   pix_vec_t      act_out_vec;
   logic          act_out_valid;
   pix_vec_t      m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last_col;
   logic          m_last_frame;
   seq_state_e    dbg_state;
`ifdef CONV2D_SEQ_PERF_EN
   logic [31:0]   perf_stall_in;
   logic [31:0]   perf_stall_out;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [PW-1:0] exp_q[$];
   acc_vec_t      src_vec [MAXV];
   vec_rec_t      tbl [6];

   conv2d_output_sequencer #(
      .OUT_FIFO_DEPTH (DEPTH),
      .DIM_WIDTH      (DW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cfg_out_w     (cfg_out_w),
      .cfg_out_h     (cfg_out_h),
      .busy          (busy),
      .done          (done),
      .acc_vec       (acc_vec),
      .acc_valid     (acc_valid),
      .acc_ready     (acc_ready),
      .act_in_vec    (act_in_vec),
      .act_in_valid  (act_in_valid),
      .act_out_vec   (act_out_vec),
      .act_out_valid (act_out_valid),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_last_col    (m_last_col),
      .m_last_frame  (m_last_frame),
      .o_dbg_state   (dbg_state)
`ifdef CONV2D_SEQ_PERF_EN
      ,
      .perf_stall_in  (perf_stall_in),
      .perf_stall_out (perf_stall_out)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic pix_vec_t act_model(input acc_vec_t a);
      pix_vec_t p;
      logic signed [ACC_WIDTH-1:0] s;
      for (int c = 0; c < NUM_OUT_CHANNELS; c++) begin
         s = a[c];
         if (s < 0)        p[c] = 8'd0;
         else if (s > 127) p[c] = 8'd127;
         else              p[c] = s[7:0];
      end
      return p;
   endfunction

   // activation stage sitting outside the sequencer: exactly one cycle of latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_out_valid <= 1'b0;
         act_out_vec   <= '0;
      end else begin
         act_out_valid <= act_in_valid;
         act_out_vec   <= act_model(act_in_vec);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_rec(input int i, input int a0, input int a1, input int a2, input int a3,
                          input int p0, input int p1, input int p2, input int p3);
      tbl[i].acc[0] = a0; tbl[i].acc[1] = a1; tbl[i].acc[2] = a2; tbl[i].acc[3] = a3;
      tbl[i].pix[0] = p0; tbl[i].pix[1] = p1; tbl[i].pix[2] = p2; tbl[i].pix[3] = p3;
   endtask

   // driver + scoreboard for one full frame
   task automatic run_frame(input string name, input int w, input int h, input bit use_tbl,
                            input int stall_at, input int stall_len, input int poke_cyc,
                            input bit expect_full);
      int            total, idx, n_out, stall_left, max_occ, occ;
      bit            acc_hs, m_hs, m_hs_last, held, stall_used, done_seen, ready_drop;
      logic [PW-1:0] held_data, exp_data;
      logic          held_lc, held_lf;
      pix_vec_t      p;
      total = w * h;
      exp_q.delete();
      for (int i = 0; i < total; i++) begin
         if (use_tbl) begin
            for (int c = 0; c < NUM_OUT_CHANNELS; c++) begin
               src_vec[i][c] = ACC_WIDTH'(tbl[i].acc[c]);
               p[c] = 8'(tbl[i].pix[c]);
            end
            exp_q.push_back(p);
         end else begin
            for (int c = 0; c < NUM_OUT_CHANNELS; c++)
               src_vec[i][c] = ACC_WIDTH'(((i * 37 + c * 53) % 300) - 60);
            exp_q.push_back(act_model(src_vec[i]));
         end
      end
      @(negedge clk);
      cfg_out_w = DW'(w); cfg_out_h = DW'(h); start = 1'b1;
      acc_valid = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, " busy"}, busy, 1);
      idx = 0; n_out = 0; stall_left = 0; max_occ = 0;
      acc_hs = 0; m_hs = 0; m_hs_last = 0; held = 0; stall_used = 0; done_seen = 0; ready_drop = 0;
      held_data = '0; held_lc = 0; held_lf = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (acc_hs) idx++;
         check({name, " done"}, done, m_hs && m_hs_last);
         if (done) begin
            done_seen = 1;
            break;
         end
         if (held)
            check({name, " hold"}, {m_valid, m_data, m_last_col, m_last_frame},
                  {1'b1, held_data, held_lc, held_lf});
         start = (cyc == poke_cyc);
         if (start) begin
            cfg_out_w = DW'(1); cfg_out_h = DW'(1);
         end
         acc_valid = 1'b1;
         acc_vec   = src_vec[(idx < MAXV) ? idx : MAXV - 1];
         if (!stall_used && stall_at > 0 && n_out == stall_at - 1 && m_valid) begin
            stall_left = stall_len;
            stall_used = 1;
         end
         m_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         #1;
         occ = idx - n_out;
         if (occ > max_occ) max_occ = occ;
         if (!acc_ready && idx < total && stall_used) ready_drop = 1;
         acc_hs = acc_valid && acc_ready;
         m_hs   = m_valid && m_ready;
         if (m_hs) begin
            if (exp_q.size() == 0) begin
               check({name, " extra output"}, 1, 0);
            end else begin
               exp_data = exp_q.pop_front();
               check($sformatf("%s data%0d", name, n_out), m_data, exp_data);
               check($sformatf("%s last_col%0d", name, n_out), m_last_col, (n_out % w) == w - 1);
               check($sformatf("%s last_frame%0d", name, n_out), m_last_frame, n_out == total - 1);
            end
            m_hs_last = m_last_frame;
            n_out++;
         end
         held = m_valid && !m_ready;
         held_data = m_data; held_lc = m_last_col; held_lf = m_last_frame;
         @(negedge clk);
      end
      start = 1'b0;
      if (!done_seen) check({name, " timeout"}, 0, 1);
      check({name, " outputs"}, n_out, total);
      check({name, " issued"}, idx, total);
      check({name, " queue empty"}, exp_q.size(), 0);
      check({name, " busy after done"}, busy, 0);
      check({name, " occupancy bound"}, max_occ <= DEPTH, 1);
      if (expect_full) begin
         check({name, " fifo filled"}, max_occ, DEPTH);
         check({name, " ready drop"}, ready_drop, 1);
      end
      acc_valid = 1'b0;
      @(negedge clk);
      check({name, " done single"}, done, 0);
      check({name, " m_valid idle"}, m_valid, 0);
   endtask

   task automatic zero_dim(input string name, input int w, input int h);
      @(negedge clk);
      cfg_out_w = DW'(w); cfg_out_h = DW'(h); start = 1'b1; acc_valid = 1'b1;
      #1;
      check({name, " busy at start"}, busy, 0);
      @(negedge clk);
      start = 1'b0;
      check({name, " done"}, done, 1);
      check({name, " busy"}, busy, 0);
      check({name, " acc_ready"}, acc_ready, 0);
      @(negedge clk);
      check({name, " done cleared"}, done, 0);
      check({name, " still idle"}, busy, 0);
      acc_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cfg_out_w = '0; cfg_out_h = '0;
      acc_vec = '0; acc_valid = 1'b0; m_ready = 1'b0;

      // {accumulator channels} -> {expected INT8 pixel channels}
      set_rec(0,      -5,      200,  64,    0,   0, 127,  64,   0);
      set_rec(1,     127,      128,  -1,    1, 127, 127,   0,   1);
      set_rec(2, 8388607, -8388608, 100, -100, 127,   0, 100,   0);
      set_rec(3,     255,      256, -128, 127, 127, 127,   0, 127);
      set_rec(4,       3,       30,  60,   90,   3,  30,  60,  90);
      set_rec(5,    1000,    -1000, 126,    2, 127,   0, 126,   2);

      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset m_valid", m_valid, 0);
      check("reset acc_ready", acc_ready, 0);
      check("reset state", dbg_state, IDLE);
      rst_n = 1'b1;

      run_frame("tbl3x2", 3, 2, 1, 0, 0, -1, 0);
      run_frame("f4x2", 4, 2, 0, 0, 0, 3, 0);
      run_frame("stall4x2", 4, 2, 0, 2, 10, -1, 1);
      zero_dim("zero_w", 0, 5);
      zero_dim("zero_h", 3, 0);
      run_frame("f1x1", 1, 1, 0, 0, 0, -1, 0);
      run_frame("f5x3", 5, 3, 0, 4, 3, 6, 0);

      // abort a 3x3 frame with reset on its third cycle
      @(negedge clk);
      cfg_out_w = DW'(3); cfg_out_h = DW'(3); start = 1'b1; m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; acc_valid = 1'b1; acc_vec = src_vec[0];
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset busy", busy, 0);
      check("midreset m_valid", m_valid, 0);
      check("midreset acc_ready", acc_ready, 0);
      check("midreset state", dbg_state, IDLE);
      @(negedge clk);
      rst_n = 1'b1; acc_valid = 1'b0; m_ready = 1'b1;
      run_frame("after_reset2x1", 2, 1, 0, 0, 0, -1, 0);

`ifdef CONV2D_SEQ_PERF_EN
      run_frame("perf2x2", 2, 2, 0, 1, 7, -1, 0);
      check("perf_stall_out", perf_stall_out, 7);
      run_frame("perf_clear", 1, 1, 0, 0, 0, -1, 0);
      check("perf_stall_out cleared", perf_stall_out, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
